// File: rtl/NXConstants.sv
// Mesh-wide constants and the node message type shared by mesh blocks.
package NXConstants;

    localparam int unsigned MESSAGE_WIDTH = 64;
    localparam int unsigned COMMAND_W     = 8;
    localparam int unsigned PAYLOAD_W     = MESSAGE_WIDTH - COMMAND_W;

    typedef struct packed {
        logic [COMMAND_W-1:0] command;
        logic [PAYLOAD_W-1:0] payload;
    } node_message_t;

endpackage

// File: rtl/nx_fifo.sv
// Small synchronous FIFO; pointers carry an extra wrap bit to tell full from empty.
module nx_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data_c,
    output logic             o_full_c,
    output logic             o_empty_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic             w_push;
    logic             w_pop;

    assign o_empty_c = (r_wr_ptr == r_rd_ptr);
    assign o_full_c  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_data_c  = r_mem[r_rd_ptr[AW-1:0]];
    assign w_push    = i_push && !o_full_c;
    assign w_pop     = i_pop && !o_empty_c;

    // Storage write; contents need no reset since pointers gate visibility
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
        end
    end

    // Read/write pointer advance
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/nx_mesh_aggregator.sv
// Merges the south-edge column streams of the mesh into one host-bound stream.
module nx_mesh_aggregator
    import NXConstants::*;
#(
    parameter int unsigned COLUMNS    = 6,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned COUNT_W    = 32
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic [COLUMNS-1:0][MESSAGE_WIDTH-1:0] i_inbound_data,
    input  logic [COLUMNS-1:0]                    i_inbound_valid,
    output logic [COLUMNS-1:0]                    o_inbound_ready,
    output logic [MESSAGE_WIDTH-1:0]              o_outbound_data,
    output logic                                  o_outbound_valid,
    input  logic                                  i_outbound_ready,
    output logic                                  o_idle,
    input  logic                                  i_count_clear,
    output logic [COUNT_W-1:0]                    o_msg_count
);

    localparam int unsigned IDX_W = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(COLUMNS - 1);

    node_message_t      w_head [COLUMNS];
    logic [COLUMNS-1:0] w_full;
    logic [COLUMNS-1:0] w_empty;
    logic [COLUMNS-1:0] w_pop;
    logic [IDX_W-1:0]   w_grant;
    logic               w_any;
    logic               w_load;
    logic               w_handshake;

    node_message_t      r_out_data;
    logic               r_out_valid;
    logic [IDX_W-1:0]   r_last;
    logic [COUNT_W-1:0] r_count;

    for (genvar c = 0; c < COLUMNS; c++) begin : g_col
        nx_fifo #(
            .WIDTH (MESSAGE_WIDTH),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .i_clk     (i_clk),
            .i_rst     (i_rst),
            .i_push    (i_inbound_valid[c]),
            .i_data    (i_inbound_data[c]),
            .i_pop     (w_pop[c]),
            .o_data_c  (w_head[c]),
            .o_full_c  (w_full[c]),
            .o_empty_c (w_empty[c])
        );
        assign w_pop[c] = w_load && (w_grant == IDX_W'(c));
    end

    // Round-robin pick: lowest non-empty column above last, else lowest overall
    always_comb begin
        w_grant = r_last;
        w_any   = 1'b0;
        for (int c = COLUMNS - 1; c >= 0; c--) begin
            if (!w_empty[c]) begin
                w_any   = 1'b1;
                w_grant = IDX_W'(c);
            end
        end
        for (int c = COLUMNS - 1; c >= 0; c--) begin
            if (!w_empty[c] && (IDX_W'(c) > r_last)) begin
                w_grant = IDX_W'(c);
            end
        end
    end

    assign w_handshake = r_out_valid && i_outbound_ready;
    assign w_load      = w_any && (!r_out_valid || i_outbound_ready);

    // Output register and arbitration pointer; both move only on a load
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_last      <= LAST_RST;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_head[w_grant];
            r_last      <= w_grant;
        end else if (w_handshake) begin
            r_out_valid <= 1'b0;
        end
    end

    // Saturating forwarded-message counter; a clear still counts a coincident handshake
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_count_clear) begin
            r_count <= COUNT_W'(w_handshake);
        end else if (w_handshake && (r_count != '1)) begin
            r_count <= r_count + COUNT_W'(1);
        end
    end

    assign o_inbound_ready  = ~w_full;
    assign o_outbound_data  = r_out_data;
    assign o_outbound_valid = r_out_valid;
    assign o_msg_count      = r_count;
    assign o_idle           = (&w_empty) && !r_out_valid && !(|i_inbound_valid);

endmodule
